// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and memory-map constants for the data-memory port arbiter.
// Region limits are byte addresses compared as 32-bit unsigned.
package dmem_port_arbiter_pkg;

  localparam int unsigned DATA_MEM_DEPTH = 4096;
  localparam int unsigned MMIO_MEM_SIZE  = 256;

  localparam logic [31:0] MEM_MAP_DATA_LOWER  = 32'h1001_0000;
  localparam logic [31:0] MEM_MAP_STACK_UPPER = 32'h7fff_effc;
  localparam logic [31:0] MEM_MAP_MMIO_LOWER  = 32'hffff_0000;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_STACK,
    REG_MMIO,
    REG_NONE
  } t_dmem_region;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_MEM_RSP,
    ARB_MMIO_WAIT,
    ARB_MMIO_RSP,
    ARB_ERR_RSP
  } t_dmem_arb_state;

endpackage

// File: rtl/dmem_region_decode.sv
// Combinational address decoder: byte address -> region plus RAM byte offset
// (DATA/STACK) or MMIO window offset (MMIO).
module dmem_region_decode
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = DATA_MEM_DEPTH,
  parameter int unsigned MMIO_BYTES = MMIO_MEM_SIZE
) (
  input  logic [31:0]  i_addr,
  output t_dmem_region o_region,
  output logic [31:0]  o_offset
);

  localparam logic [31:0] DIV        = 32'(MEM_BYTES / 2);
  localparam logic [31:0] MMIO_SZ    = 32'(MMIO_BYTES);
  localparam logic [31:0] STACK_LL   = MEM_MAP_STACK_UPPER - DIV;
  localparam logic [31:0] DATA_LAST  = MEM_MAP_DATA_LOWER + DIV - 32'd1;
  localparam logic [31:0] STACK_LAST = MEM_MAP_STACK_UPPER + 32'd3;

  // The stack grows down from STACK_UPPER and is folded onto the upper RAM half.
  always_comb begin
    o_region = REG_NONE;
    o_offset = '0;
    if (i_addr >= MEM_MAP_DATA_LOWER && i_addr <= DATA_LAST) begin
      o_region = REG_DATA;
      o_offset = i_addr - MEM_MAP_DATA_LOWER;
    end else if (i_addr > STACK_LL && i_addr <= STACK_LAST) begin
      o_region = REG_STACK;
      o_offset = i_addr - STACK_LL - 32'd4 + DIV;
    end else if (i_addr >= MEM_MAP_MMIO_LOWER && (i_addr - MEM_MAP_MMIO_LOWER) < MMIO_SZ) begin
      o_region = REG_MMIO;
      o_offset = i_addr - MEM_MAP_MMIO_LOWER;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between LSU (0) and debug (1),
// routing to RAM or MMIO. Define DMEM_ARB_TIMEOUT_EN to bound the MMIO ack wait.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = DATA_MEM_DEPTH,
  parameter int unsigned MMIO_BYTES   = MMIO_MEM_SIZE,
  parameter int unsigned MMIO_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_i,
  input  logic [1:0]                    we_i,
  input  logic [1:0][31:0]              addr_i,
  input  logic [1:0][31:0]              wdata_i,
  input  logic [1:0][3:0]               be_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    rvalid_o,
  output logic [31:0]                   rdata_o,
  output logic                          err_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [$clog2(MEM_BYTES)-3:0]  mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic [31:0]                   mem_rdata_i,
  output logic                          mmio_req_o,
  output logic                          mmio_we_o,
  output logic [31:0]                   mmio_addr_o,
  output logic [31:0]                   mmio_wdata_o,
  output logic [3:0]                    mmio_be_o,
  input  logic                          mmio_ack_i,
  input  logic [31:0]                   mmio_rdata_i
);

  localparam int unsigned AW = $clog2(MEM_BYTES) - 2;

  t_dmem_arb_state r_state, w_state_nxt;
  logic            r_rr_ptr;
  logic            r_port;
  logic            r_we;
  logic [31:0]     r_mmio_addr;
  logic [31:0]     r_mmio_wdata;
  logic [3:0]      r_mmio_be;
  logic [31:0]     r_mmio_rdata;

  logic            w_sel;
  logic            w_grant;
  logic            w_timeout;
  t_dmem_region    w_region;
  logic [31:0]     w_offset;

  assign w_sel   = (req_i == 2'b11) ? r_rr_ptr : req_i[1];
  assign w_grant = (r_state == ARB_IDLE) && (|req_i) && !rst;

  dmem_region_decode #(
    .MEM_BYTES  (MEM_BYTES),
    .MMIO_BYTES (MMIO_BYTES)
  ) u_decode (
    .i_addr   (addr_i[w_sel]),
    .o_region (w_region),
    .o_offset (w_offset)
  );

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MMIO_TIMEOUT + 1);
  logic [CW-1:0] r_tmo_cnt;

  assign w_timeout = (r_tmo_cnt == CW'(MMIO_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_tmo_cnt <= '0;
    else if (w_grant)                r_tmo_cnt <= '0;
    else if (r_state == ARB_MMIO_WAIT) r_tmo_cnt <= r_tmo_cnt + CW'(1);
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^MMIO_TIMEOUT;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_rr_ptr     <= 1'b0;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
      r_mmio_be    <= '0;
      r_mmio_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr_ptr     <= ~w_sel;
        r_port       <= w_sel;
        r_we         <= we_i[w_sel];
        r_mmio_addr  <= w_offset;
        r_mmio_wdata <= wdata_i[w_sel];
        r_mmio_be    <= be_i[w_sel];
      end
      if (r_state == ARB_MMIO_WAIT && mmio_ack_i)
        r_mmio_rdata <= r_we ? 32'd0 : mmio_rdata_i;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    gnt_o        = '0;
    rvalid_o     = '0;
    rdata_o      = '0;
    err_o        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    mmio_req_o   = 1'b0;
    mmio_we_o    = 1'b0;
    mmio_addr_o  = '0;
    mmio_wdata_o = '0;
    mmio_be_o    = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) begin
          gnt_o[w_sel] = 1'b1;
          case (w_region)
            REG_DATA, REG_STACK: begin
              mem_req_o   = 1'b1;
              mem_we_o    = we_i[w_sel];
              mem_addr_o  = w_offset[AW+1:2];
              mem_wdata_o = wdata_i[w_sel];
              mem_be_o    = be_i[w_sel];
              w_state_nxt = ARB_MEM_RSP;
            end
            REG_MMIO: begin
              mmio_req_o   = 1'b1;
              mmio_we_o    = we_i[w_sel];
              mmio_addr_o  = w_offset;
              mmio_wdata_o = wdata_i[w_sel];
              mmio_be_o    = be_i[w_sel];
              w_state_nxt  = ARB_MMIO_WAIT;
            end
            default: w_state_nxt = ARB_ERR_RSP;
          endcase
        end
      end
      ARB_MEM_RSP: begin
        rvalid_o[r_port] = 1'b1;
        rdata_o          = r_we ? 32'd0 : mem_rdata_i;
        w_state_nxt      = ARB_IDLE;
      end
      ARB_MMIO_WAIT: begin
        // Request stays up through the ack (or timeout) cycle so ack can win the tie.
        mmio_req_o   = 1'b1;
        mmio_we_o    = r_we;
        mmio_addr_o  = r_mmio_addr;
        mmio_wdata_o = r_mmio_wdata;
        mmio_be_o    = r_mmio_be;
        if (mmio_ack_i)     w_state_nxt = ARB_MMIO_RSP;
        else if (w_timeout) w_state_nxt = ARB_ERR_RSP;
      end
      ARB_MMIO_RSP: begin
        rvalid_o[r_port] = 1'b1;
        rdata_o          = r_mmio_rdata;
        w_state_nxt      = ARB_IDLE;
      end
      ARB_ERR_RSP: begin
        rvalid_o[r_port] = 1'b1;
        err_o            = 1'b1;
        w_state_nxt      = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter (default map: 4 KiB RAM, 256 B MMIO).
// Timeout scenario is included when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  be;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic [31:0]      rdata;
  logic             err;
  logic             mem_req;
  logic             mem_we;
  logic [9:0]       mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata;
  logic             mmio_req;
  logic             mmio_we;
  logic [31:0]      mmio_addr;
  logic [31:0]      mmio_wdata;
  logic [3:0]       mmio_be;
  logic             mmio_ack;
  logic [31:0]      mmio_rdata;

  logic [31:0] ram [0:1023];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .be_i         (be),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .err_o        (err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_rdata_i  (mem_rdata),
    .mmio_req_o   (mmio_req),
    .mmio_we_o    (mmio_we),
    .mmio_addr_o  (mmio_addr),
    .mmio_wdata_o (mmio_wdata),
    .mmio_be_o    (mmio_be),
    .mmio_ack_i   (mmio_ack),
    .mmio_rdata_i (mmio_rdata)
  );

  // RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] exp_d [4] = '{32'hDEAD_BEEF, 32'hA500_0004, 32'hDEAD_BEEF, 32'hA500_0004};

  initial begin
    int n;
    logic got;
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | 32'(i);
    mem_rdata = '0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    mmio_ack = 1'b0; mmio_rdata = '0;

    // Reset state, including a request held during reset
    tick(); #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_err", 32'(err), 0);
    req = 2'b11; #1;
    chk("rst_gnt_held", 32'(gnt), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mmio_req", 32'(mmio_req), 0);
    tick(); req = '0; rst = 1'b0;

    // Port 0 write then read of a .data word
    tick(); req = 2'b01; we[0] = 1'b1; addr[0] = 32'h1001_0008;
    wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF; #1;
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_mem_req", 32'(mem_req), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 2);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_mem_be", 32'(mem_be), 32'hF);
    tick(); req = '0; we = '0; #1;
    chk("wr_rvalid", 32'(rvalid), 32'h1);
    chk("wr_rdata", rdata, 0);
    chk("wr_err", 32'(err), 0);
    tick(); req = 2'b01; #1;
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 2);
    tick(); req = '0; #1;
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);

    // Fresh reset, then both ports requesting continuously
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0;
    addr[0] = 32'h1001_0008; addr[1] = 32'h1001_0010; be[1] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick(); req = 2'b11; #1;
      chk("rr_gnt", 32'(gnt), 32'(exp_g[k]));
      tick(); #1;
      chk("rr_rvalid", 32'(rvalid), 32'(exp_g[k]));
      chk("rr_rdata", rdata, exp_d[k]);
      chk("rr_wait_mid", 32'(gnt), 0);
    end
    req = '0;

    // Top stack word and last .data word
    tick(); req = 2'b01; addr[0] = 32'h7fff_effc; #1;
    chk("stk_mem_req", 32'(mem_req), 1);
    chk("stk_mem_addr", 32'(mem_addr), 1023);
    tick(); req = '0; #1;
    chk("stk_rdata", rdata, 32'hA500_03FF);
    tick(); req = 2'b01; addr[0] = 32'h1001_07fc; #1;
    chk("data_last_addr", 32'(mem_addr), 511);
    tick(); req = '0; #1;
    chk("data_last_rdata", rdata, 32'hA500_01FF);

    // Stack lower limit itself is unmapped
    tick(); req = 2'b01; addr[0] = 32'h7fff_e7fc; #1;
    chk("stkll_gnt", 32'(gnt), 32'h1);
    chk("stkll_mem_req", 32'(mem_req), 0);
    chk("stkll_mmio_req", 32'(mmio_req), 0);
    tick(); req = '0; #1;
    chk("stkll_rvalid", 32'(rvalid), 32'h1);
    chk("stkll_err", 32'(err), 1);
    chk("stkll_rdata", rdata, 0);
    chk("stkll_mem_req_rsp", 32'(mem_req), 0);

    // One past the .data half, from port 1
    tick(); req = 2'b10; addr[1] = 32'h1001_0800; #1;
    chk("data_end_gnt", 32'(gnt), 32'h2);
    chk("data_end_mem_req", 32'(mem_req), 0);
    tick(); req = '0; #1;
    chk("data_end_rvalid", 32'(rvalid), 32'h2);
    chk("data_end_err", 32'(err), 1);

    // MMIO read, ack on the third cycle after grant
    tick(); req = 2'b10; addr[1] = 32'hffff_0010; #1;
    chk("mmio_gnt", 32'(gnt), 32'h2);
    chk("mmio_req_t0", 32'(mmio_req), 1);
    chk("mmio_addr_t0", mmio_addr, 32'h10);
    chk("mmio_mem_req", 32'(mem_req), 0);
    for (int c = 1; c <= 2; c++) begin
      tick(); req = '0; #1;
      chk("mmio_req_hold", 32'(mmio_req), 1);
      chk("mmio_addr_hold", mmio_addr, 32'h10);
      chk("mmio_no_rvalid", 32'(rvalid), 0);
    end
    tick(); mmio_ack = 1'b1; mmio_rdata = 32'h55; #1;
    chk("mmio_req_ack", 32'(mmio_req), 1);
    chk("mmio_addr_ack", mmio_addr, 32'h10);
    tick(); mmio_ack = 1'b0; mmio_rdata = '0; #1;
    chk("mmio_rvalid", 32'(rvalid), 32'h2);
    chk("mmio_rdata", rdata, 32'h55);
    chk("mmio_err", 32'(err), 0);
    chk("mmio_req_done", 32'(mmio_req), 0);

    // First byte past the MMIO window
    tick(); req = 2'b01; addr[0] = 32'hffff_0100; #1;
    chk("mmio_end_req", 32'(mmio_req), 0);
    tick(); req = '0; #1;
    chk("mmio_end_rvalid", 32'(rvalid), 32'h1);
    chk("mmio_end_err", 32'(err), 1);

`ifdef DMEM_ARB_TIMEOUT_EN
    // MMIO never acks: error response 17 cycles after the grant
    tick(); req = 2'b01; addr[0] = 32'hffff_0020; #1;
    chk("tmo_req", 32'(mmio_req), 1);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick(); req = '0; n++; #1;
      if (rvalid != 2'b00) got = 1'b1;
    end
    chk("tmo_cycles", 32'(n), 17);
    chk("tmo_rvalid", 32'(rvalid), 32'h1);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_rdata", rdata, 0);
    chk("tmo_req_drop", 32'(mmio_req), 0);
    tick(); #1;
    chk("tmo_idle", 32'(rvalid), 0);
`endif

    // Reset while waiting on MMIO
    tick(); req = 2'b01; addr[0] = 32'hffff_0004; #1;
    chk("rstw_gnt", 32'(gnt), 32'h1);
    tick(); req = '0; #1;
    chk("rstw_req_before", 32'(mmio_req), 1);
    rst = 1'b1; #1;
    chk("rstw_mmio_req", 32'(mmio_req), 0);
    chk("rstw_mmio_addr", mmio_addr, 0);
    chk("rstw_rvalid", 32'(rvalid), 0);
    tick(); rst = 1'b0; #1;
    chk("rstw_no_rsp1", 32'(rvalid), 0);
    chk("rstw_mmio_idle", 32'(mmio_req), 0);
    tick(); #1;
    chk("rstw_no_rsp2", 32'(rvalid), 0);
    tick(); req = 2'b10; addr[1] = 32'h1001_0008; #1;
    chk("rstw_next_gnt", 32'(gnt), 32'h2);
    chk("rstw_next_addr", 32'(mem_addr), 2);
    tick(); req = '0; #1;
    chk("rstw_next_rvalid", 32'(rvalid), 32'h2);
    chk("rstw_next_rdata", rdata, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
